// File: rtl/mem_stage.sv
// MEM pipeline stage: word-organised data memory with byte/half/word access,
// alignment checking, load extension and the MEM/WB pipeline register.
module mem_stage #(
    parameter int AW = 10
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Flush,
    input  logic        in_valid,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_signal,
    input  logic [31:0] in_r,
    input  logic [31:0] in_b,
    input  logic [31:0] in_v0,
    input  logic [31:0] in_a0,
    output logic [31:0] out_pc,
    output logic [31:0] out_signal,
    output logic [31:0] out_r,
    output logic [31:0] out_v0,
    output logic [31:0] out_a0,
    output logic [31:0] out_d,
    output logic        out_valid,
    output logic        out_misalign,
    output logic [15:0] out_mem_count
);

    localparam int DEPTH = 1 << AW;

    logic [31:0]   mem [DEPTH];

    logic [AW-1:0] mem_index;
    logic [31:0]   rd_word;
    logic          mem_to_reg;
    logic          mem_write;
    logic          load_unsigned;
    logic          is_byte;
    logic          is_half;
    logic          is_word;
    logic          misaligned;
    logic          access;
    logic          fault;
    logic          store_en;
    logic          count_en;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_data;
    logic [31:0]   wr_word;
    logic [31:0]   d_next;

    // Upper address bits are dropped, so addresses alias every 2^AW words.
    assign mem_index     = in_r[AW+1:2];
    assign rd_word       = mem[mem_index];

    assign mem_to_reg    = in_signal[3];
    assign mem_write     = in_signal[4];
    assign load_unsigned = in_signal[18];
    assign is_byte       = (in_signal[17:16] == 2'b10);
    assign is_half       = (in_signal[17:16] == 2'b01);
    assign is_word       = ~is_byte & ~is_half;

    assign misaligned    = (is_half & in_r[0]) | (is_word & (in_r[1:0] != 2'b00));
    assign access        = in_valid & (mem_to_reg | mem_write);
    assign fault         = access & misaligned;
    assign store_en      = in_valid & mem_write & ~misaligned & ~Stall & ~Flush & ~Reset;
    assign count_en      = access & ~misaligned & ~Stall & ~Flush;

    // Lane selection and sign/zero extension of the combinationally read word.
    always_comb begin
        byte_sel  = rd_word[{in_r[1:0], 3'b000} +: 8];
        half_sel  = in_r[1] ? rd_word[31:16] : rd_word[15:0];
        load_data = rd_word;
        if (is_byte) begin
            load_data = load_unsigned ? {24'b0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
        end else if (is_half) begin
            load_data = load_unsigned ? {16'b0, half_sel} : {{16{half_sel[15]}}, half_sel};
        end
    end

    // Narrow stores merge into the current word so untouched lanes survive.
    always_comb begin
        wr_word = rd_word;
        if (is_byte) begin
            wr_word[{in_r[1:0], 3'b000} +: 8] = in_b[7:0];
        end else if (is_half) begin
            if (in_r[1]) begin
                wr_word[31:16] = in_b[15:0];
            end else begin
                wr_word[15:0] = in_b[15:0];
            end
        end else begin
            wr_word = in_b;
        end
    end

    assign d_next = (in_valid & mem_to_reg & ~misaligned) ? load_data : 32'b0;

    // Memory has no reset; the read above sees the pre-write contents this cycle.
    always_ff @(posedge Clock) begin
        if (store_en) begin
            mem[mem_index] <= wr_word;
        end
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            out_pc        <= 32'b0;
            out_signal    <= 32'b0;
            out_r         <= 32'b0;
            out_v0        <= 32'b0;
            out_a0        <= 32'b0;
            out_d         <= 32'b0;
            out_valid     <= 1'b0;
            out_misalign  <= 1'b0;
            out_mem_count <= 16'b0;
        end else if (Flush) begin
            out_pc        <= in_pc;
            out_signal    <= 32'b0;
            out_r         <= in_r;
            out_v0        <= in_v0;
            out_a0        <= in_a0;
            out_d         <= 32'b0;
            out_valid     <= 1'b0;
            out_misalign  <= 1'b0;
        end else if (!Stall) begin
            out_pc        <= in_pc;
            out_signal    <= in_valid ? in_signal : 32'b0;
            out_r         <= in_r;
            out_v0        <= in_v0;
            out_a0        <= in_a0;
            out_d         <= d_next;
            out_valid     <= in_valid;
            out_misalign  <= fault;
            out_mem_count <= out_mem_count + {15'b0, count_en};
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus randomized traffic
// checked against a word-array reference model of the stage.
module tb_mem_stage;

    localparam int AW = 10;
    localparam logic [31:0] SIG_LD = 32'h0000_0008;
    localparam logic [31:0] SIG_ST = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        reset, stall, flush, in_valid;
    logic [31:0] in_pc, in_signal, in_r, in_b, in_v0, in_a0;
    logic [31:0] out_pc, out_signal, out_r, out_v0, out_a0, out_d;
    logic        out_valid, out_misalign;
    logic [15:0] out_mem_count;

    int total = 0;
    int bad   = 0;

    logic [31:0] mdl_mem [1 << AW];
    logic [31:0] e_pc, e_signal, e_r, e_v0, e_a0, e_d;
    logic        e_valid, e_mis;
    logic [15:0] e_cnt;

    logic [209:0] obs_vec, exp_vec;
    assign obs_vec = {out_pc, out_signal, out_r, out_v0, out_a0, out_d, out_valid, out_misalign, out_mem_count};
    assign exp_vec = {e_pc, e_signal, e_r, e_v0, e_a0, e_d, e_valid, e_mis, e_cnt};

    typedef struct {
        logic [31:0] sg;
        logic [31:0] r;
        logic [31:0] b;
        logic [31:0] want_d;
        logic        want_mis;
        logic [15:0] want_cnt;
    } dir_t;

    always #5 clk = ~clk;

    mem_stage #(.AW(AW)) dut (
        .Clock(clk), .Reset(reset), .Stall(stall), .Flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_signal(in_signal), .in_r(in_r),
        .in_b(in_b), .in_v0(in_v0), .in_a0(in_a0),
        .out_pc(out_pc), .out_signal(out_signal), .out_r(out_r), .out_v0(out_v0),
        .out_a0(out_a0), .out_d(out_d), .out_valid(out_valid),
        .out_misalign(out_misalign), .out_mem_count(out_mem_count)
    );

    function automatic logic [31:0] make_sig(bit ld, bit st, logic [1:0] size, bit uns);
        return (ld ? SIG_LD : 32'b0) | (st ? SIG_ST : 32'b0) | {13'b0, uns, size, 16'b0};
    endfunction

    // Reference model: what the MEM/WB register and memory should hold after the next edge.
    task automatic model_step();
        int nbytes, off, idx;
        logic [31:0] word, v, mask;
        bit ld, st, mis;
        if (reset) begin
            e_pc = '0; e_signal = '0; e_r = '0; e_v0 = '0; e_a0 = '0; e_d = '0;
            e_valid = 1'b0; e_mis = 1'b0; e_cnt = '0;
        end else if (flush) begin
            e_pc = in_pc; e_r = in_r; e_v0 = in_v0; e_a0 = in_a0;
            e_signal = '0; e_d = '0; e_valid = 1'b0; e_mis = 1'b0;
        end else if (!stall) begin
            e_pc = in_pc; e_r = in_r; e_v0 = in_v0; e_a0 = in_a0;
            if (!in_valid) begin
                e_signal = '0; e_d = '0; e_valid = 1'b0; e_mis = 1'b0;
            end else begin
                idx  = int'(in_r[AW+1:2]);
                word = mdl_mem[idx];
                case (in_signal[17:16])
                    2'b01:   nbytes = 2;
                    2'b10:   nbytes = 1;
                    default: nbytes = 4;
                endcase
                off  = (nbytes == 1) ? int'(in_r[1:0]) : (nbytes == 2) ? 2 * int'(in_r[1]) : 0;
                mis  = (nbytes == 2 && in_r[0]) || (nbytes == 4 && in_r[1:0] != 2'b00);
                ld   = in_signal[3];
                st   = in_signal[4];
                e_valid  = 1'b1;
                e_signal = in_signal;
                e_mis    = (ld || st) && mis;
                e_d      = '0;
                if ((ld || st) && !mis) begin
                    e_cnt = e_cnt + 16'd1;
                    if (ld) begin
                        v = word >> (8 * off);
                        if (nbytes == 1) begin
                            v = v & 32'h0000_00FF;
                            if (!in_signal[18] && v[7]) v = v | 32'hFFFF_FF00;
                        end else if (nbytes == 2) begin
                            v = v & 32'h0000_FFFF;
                            if (!in_signal[18] && v[15]) v = v | 32'hFFFF_0000;
                        end
                        e_d = v;
                    end
                    if (st) begin
                        mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1) << (8 * off);
                        mdl_mem[idx] = (word & ~mask) | ((in_b << (8 * off)) & mask);
                    end
                end
            end
        end
    endtask

    task automatic apply_stimulus(input bit rst, input bit stl, input bit fl, input bit v,
                                  input logic [31:0] pc, input logic [31:0] sg,
                                  input logic [31:0] r, input logic [31:0] b);
        reset = rst; stall = stl; flush = fl; in_valid = v;
        in_pc = pc; in_signal = sg; in_r = r; in_b = b;
        in_v0 = $urandom; in_a0 = $urandom;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        apply_stimulus(1, 1, 1, 1, $urandom, make_sig(1, 1, 2'b00, 0), 32'h40, $urandom);
        total++;
        if (obs_vec !== 210'b0) begin
            bad++;
            $display("[TB] FAIL reset_zero got=%h want=0", obs_vec);
        end
        total++;
        if (obs_vec !== exp_vec) begin
            bad++;
            $display("[TB] FAIL reset_model got=%h want=%h", obs_vec, exp_vec);
        end
    endtask

    task automatic test_init_mem();
        for (int i = 0; i < 32; i++) begin
            apply_stimulus(0, 0, 0, 1, $urandom, make_sig(0, 1, 2'b00, 0),
                           ($urandom & 32'hFFFF_F000) | (i << 2), $urandom);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++;
                $display("[TB] FAIL init_sw[%0d] got=%h want=%h", i, obs_vec, exp_vec);
            end
        end
        apply_stimulus(1, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_directed();
        dir_t tbl [9];
        tbl[0] = '{make_sig(0, 1, 2'b00, 0), 32'h10, 32'h1122_3344, 32'h0,         1'b0, 16'd1};
        tbl[1] = '{make_sig(1, 0, 2'b00, 0), 32'h10, 32'h0,         32'h1122_3344, 1'b0, 16'd2};
        tbl[2] = '{make_sig(0, 1, 2'b10, 0), 32'h11, 32'hDEAD_BEAB, 32'h0,         1'b0, 16'd3};
        tbl[3] = '{make_sig(1, 0, 2'b00, 0), 32'h10, 32'h0,         32'h1122_AB44, 1'b0, 16'd4};
        tbl[4] = '{make_sig(1, 0, 2'b10, 0), 32'h11, 32'h0,         32'hFFFF_FFAB, 1'b0, 16'd5};
        tbl[5] = '{make_sig(1, 0, 2'b10, 1), 32'h11, 32'h0,         32'h0000_00AB, 1'b0, 16'd6};
        tbl[6] = '{make_sig(0, 1, 2'b01, 0), 32'h12, 32'h5555_8001, 32'h0,         1'b0, 16'd7};
        tbl[7] = '{make_sig(1, 0, 2'b01, 0), 32'h12, 32'h0,         32'hFFFF_8001, 1'b0, 16'd8};
        tbl[8] = '{make_sig(1, 0, 2'b00, 0), 32'h13, 32'h0,         32'h0,         1'b1, 16'd8};
        for (int i = 0; i < 9; i++) begin
            apply_stimulus(0, 0, 0, 1, $urandom, tbl[i].sg, tbl[i].r, tbl[i].b);
            total++;
            if (out_d !== tbl[i].want_d) begin
                bad++;
                $display("[TB] FAIL dir_d[%0d] got=%h want=%h", i, out_d, tbl[i].want_d);
            end
            total++;
            if (out_misalign !== tbl[i].want_mis || out_mem_count !== tbl[i].want_cnt) begin
                bad++;
                $display("[TB] FAIL dir_mis_cnt[%0d] got=%b/%0d want=%b/%0d", i,
                         out_misalign, out_mem_count, tbl[i].want_mis, tbl[i].want_cnt);
            end
            total++;
            if (out_signal !== tbl[i].sg || out_valid !== 1'b1) begin
                bad++;
                $display("[TB] FAIL dir_sig[%0d] got=%h/%b want=%h/1", i, out_signal, out_valid, tbl[i].sg);
            end
        end
    endtask

    task automatic test_stall();
        logic [15:0] c0;
        logic [31:0] data;
        data = $urandom;
        apply_stimulus(0, 0, 0, 1, $urandom, make_sig(1, 0, 2'b00, 0), 32'h04, 0);
        c0 = e_cnt;
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(0, 1, 0, 1, $urandom, make_sig(0, 1, 2'b00, 0), 32'h20, data);
            total++;
            if (obs_vec !== exp_vec || out_mem_count !== c0) begin
                bad++;
                $display("[TB] FAIL stall_hold[%0d] got=%h want=%h", i, obs_vec, exp_vec);
            end
        end
        apply_stimulus(0, 0, 0, 1, $urandom, make_sig(0, 1, 2'b00, 0), 32'h20, data);
        total++;
        if (out_mem_count !== c0 + 16'd1 || obs_vec !== exp_vec) begin
            bad++;
            $display("[TB] FAIL stall_release got=%0d want=%0d", out_mem_count, c0 + 16'd1);
        end
        apply_stimulus(0, 0, 0, 1, $urandom, make_sig(1, 0, 2'b00, 0), 32'h20, 0);
        total++;
        if (out_d !== data) begin
            bad++;
            $display("[TB] FAIL stall_readback got=%h want=%h", out_d, data);
        end
    endtask

    task automatic test_flush();
        logic [31:0] prev;
        logic [15:0] c0;
        prev = mdl_mem[12];
        c0   = e_cnt;
        apply_stimulus(0, 1, 1, 1, 32'h1234, make_sig(0, 1, 2'b00, 0), 32'h30, ~prev);
        total++;
        if (out_valid !== 1'b0 || out_signal !== 32'b0 || out_mem_count !== c0 || out_pc !== 32'h1234) begin
            bad++;
            $display("[TB] FAIL flush_regs got=%b/%h/%0d/%h want=0/0/%0d/1234",
                     out_valid, out_signal, out_mem_count, out_pc, c0);
        end
        apply_stimulus(0, 0, 0, 1, $urandom, make_sig(1, 0, 2'b00, 0), 32'h30, 0);
        total++;
        if (out_d !== prev) begin
            bad++;
            $display("[TB] FAIL flush_mem got=%h want=%h", out_d, prev);
        end
    endtask

    task automatic test_random();
        logic [31:0] sg, r;
        for (int i = 0; i < 400; i++) begin
            sg = make_sig($urandom_range(1), $urandom_range(1), 2'($urandom_range(3)), $urandom_range(1))
                 | ($urandom & ~32'h0007_0018);
            r  = ($urandom & 32'hFFFF_F000) | ($urandom_range(31) << 2) | 32'($urandom_range(3));
            apply_stimulus($urandom_range(99) < 2, $urandom_range(99) < 15, $urandom_range(99) < 10,
                           $urandom_range(99) < 90, $urandom, sg, r, $urandom);
            total++;
            if (obs_vec !== exp_vec) begin
                bad++;
                $display("[TB] FAIL rand[%0d] got=%h want=%h", i, obs_vec, exp_vec);
            end
        end
    endtask

    task automatic test_wrap();
        int guard = 0;
        while (e_cnt != 16'hFFFF && guard < 70000) begin
            apply_stimulus(0, 0, 0, 1, 0, make_sig(1, 0, 2'b00, 0), 32'h0, 0);
            guard++;
        end
        total++;
        if (out_mem_count !== 16'hFFFF) begin
            bad++;
            $display("[TB] FAIL wrap_preload got=%h want=ffff", out_mem_count);
        end
        apply_stimulus(0, 0, 0, 1, 0, make_sig(1, 0, 2'b00, 0), 32'h4, 0);
        total++;
        if (out_mem_count !== 16'h0000) begin
            bad++;
            $display("[TB] FAIL wrap_zero got=%h want=0000", out_mem_count);
        end
        apply_stimulus(0, 0, 0, 1, $urandom, make_sig(1, 0, 2'b00, 0), 32'h8, 0);
        apply_stimulus(1, 1, 0, 1, $urandom, make_sig(1, 0, 2'b00, 0), 32'h8, 0);
        total++;
        if (obs_vec !== 210'b0) begin
            bad++;
            $display("[TB] FAIL reset_over_stall got=%h want=0", obs_vec);
        end
        for (int i = 0; i < 2; i++) begin
            apply_stimulus(0, 1, 0, 1, $urandom, make_sig(1, 0, 2'b00, 0), 32'h8, 0);
            total++;
            if (obs_vec !== 210'b0) begin
                bad++;
                $display("[TB] FAIL post_reset_stall[%0d] got=%h want=0", i, obs_vec);
            end
        end
        apply_stimulus(0, 0, 0, 1, $urandom, make_sig(1, 0, 2'b00, 0), 32'h8, 0);
        total++;
        if (obs_vec !== exp_vec || out_valid !== 1'b1 || out_mem_count !== 16'd1) begin
            bad++;
            $display("[TB] FAIL post_reset_release got=%h want=%h", obs_vec, exp_vec);
        end
    endtask

    initial begin
        reset = 1'b0; stall = 1'b0; flush = 1'b0; in_valid = 1'b0;
        in_pc = '0; in_signal = '0; in_r = '0; in_b = '0; in_v0 = '0; in_a0 = '0;
        e_pc = '0; e_signal = '0; e_r = '0; e_v0 = '0; e_a0 = '0; e_d = '0;
        e_valid = 1'b0; e_mis = 1'b0; e_cnt = '0;
        @(negedge clk);
        test_reset();
        test_init_mem();
        test_directed();
        test_stall();
        test_flush();
        test_random();
        test_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
